// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding and config clamps for the MAC dot-product sequencer
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    CAPT = 2'd2
  } state_t;

  localparam int SHIFT_MAX = 24;

  function automatic int clamp_ntaps(input int n, input int nmax);
    if (n < 1) return 1;
    if (n > nmax) return nmax;
    return n;
  endfunction

  function automatic logic [4:0] clamp_shift(input logic [4:0] s);
    return (int'(s) > SHIFT_MAX) ? 5'(SHIFT_MAX) : s;
  endfunction

endpackage

// File: rtl/mac_coef_rf.sv
// rtl/mac_coef_rf.sv - coefficient register file, one write port and one combinational read port
module mac_coef_rf #(
  parameter int NTAP_MAX = 16,
  parameter int TAP_AW   = 4
) (
  input  logic              MAC_ACC_CLK,
  input  logic              we,
  input  logic [TAP_AW-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [TAP_AW-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [NTAP_MAX];

  // Contents survive reset so software need not reload taps after an abort
  always_ff @(posedge MAC_ACC_CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - operand/coefficient sequencer driving the 16-bit MAC, one result per vector
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int NTAP_MAX = 16,
  parameter int TAP_AW   = 4
) (
  input  logic              MAC_ACC_CLK,
  input  logic              acc_ff_rstn,
  input  logic [TAP_AW:0]   cfg_ntaps,
  input  logic [4:0]        cfg_shift,
  input  logic              cfg_rnd,
  input  logic              cfg_sat,
  input  logic              cfg_tc,
  input  logic              coef_we,
  input  logic [TAP_AW-1:0] coef_addr,
  input  logic [15:0]       coef_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              busy,
  output logic [15:0]       MAC_OPER_DATA,
  output logic [15:0]       MAC_COEF_DATA,
  output logic              EFPGA_MATHB_CLK_EN,
  output logic              MAC_ACC_CLEAR,
  output logic              MAC_ACC_RND,
  output logic              MAC_ACC_SAT,
  output logic [5:0]        MAC_OUT_SEL,
  output logic              MAC_TC,
  input  logic [15:0]       MAC_OUT
);

  localparam logic [TAP_AW:0] ONE_N = (TAP_AW+1)'(1);

  state_t            state;
  logic [TAP_AW-1:0] tap_cnt;
  logic [TAP_AW:0]   ntaps_q;
  logic [TAP_AW:0]   ntaps_c;
  logic [4:0]        shift_q;
  logic              sat_q;
  logic              tc_q;
  logic              idle;
  logic              beat;
  logic              coef_wr;

  assign idle     = (state == IDLE);
  assign in_ready = acc_ff_rstn && (state != CAPT);
  assign beat     = in_valid && in_ready;
  assign busy     = !idle;
  assign coef_wr  = coef_we && idle && !beat;
  assign ntaps_c  = (TAP_AW+1)'(clamp_ntaps(int'(cfg_ntaps), NTAP_MAX));

  mac_coef_rf #(
    .NTAP_MAX (NTAP_MAX),
    .TAP_AW   (TAP_AW)
  ) u_coef_rf (
    .MAC_ACC_CLK (MAC_ACC_CLK),
    .we          (coef_wr),
    .waddr       (coef_addr),
    .wdata       (coef_wdata),
    .raddr       (tap_cnt),
    .rdata       (MAC_COEF_DATA)
  );

  // Rounding only enters through the first beat's feedback term, so rnd is never latched
  assign MAC_OPER_DATA      = in_data;
  assign EFPGA_MATHB_CLK_EN = beat;
  assign MAC_ACC_CLEAR      = idle && !cfg_rnd;
  assign MAC_ACC_RND        = idle && cfg_rnd;
  assign MAC_OUT_SEL        = {1'b0, idle ? clamp_shift(cfg_shift) : shift_q};
  assign MAC_ACC_SAT        = idle ? cfg_sat : sat_q;
  assign MAC_TC             = idle ? cfg_tc : tc_q;

  always_ff @(posedge MAC_ACC_CLK) begin
    if (!acc_ff_rstn) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      ntaps_q   <= '0;
      shift_q   <= '0;
      sat_q     <= 1'b0;
      tc_q      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (beat) begin
            ntaps_q <= ntaps_c;
            shift_q <= clamp_shift(cfg_shift);
            sat_q   <= cfg_sat;
            tc_q    <= cfg_tc;
            if (ntaps_c == ONE_N) begin
              state <= CAPT;
            end else begin
              state   <= ACC;
              tap_cnt <= TAP_AW'(1);
            end
          end
        end
        ACC: begin
          if (beat) begin
            if ({1'b0, tap_cnt} == ntaps_q - ONE_N) begin
              state   <= CAPT;
              tap_cnt <= '0;
            end else begin
              tap_cnt <= tap_cnt + 1'b1;
            end
          end
        end
        CAPT: begin
          if (!out_valid || out_ready) begin
            out_data  <= MAC_OUT;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
